// File: rtl/huff_pkg.sv
// huff_pkg: shared sizes, FSM state type and snapshot record for the
// sequential Huffman encoder wrapper (huff_enc_seq) and its character buffer.
//
// Contents:
//   MAX_CHAR_LENGTH  characters per block (must match the encoder build)
//   CODE_W           code width per position (2*6+3)
//   LEN_W            width of the code-length field
//   CHAR_W           width of one character
//   CNT_W            width of enc_count and of the block pointers
//   seq_state_t      FILL / SETTLE / EMIT
//   huff_sym_t       one captured symbol: char, code, len
package huff_pkg;

    localparam int MAX_CHAR_LENGTH = 5;
    localparam int CODE_W          = 15;
    localparam int LEN_W           = 4;
    localparam int CHAR_W          = 7;
    localparam int CNT_W           = 3;

    localparam int               SETTLE_CYCLES_DEF = 2;
    localparam logic [CHAR_W-1:0] PAD_CHAR_DEF     = 7'h00;

    typedef enum logic [1:0] {
        FILL,
        SETTLE,
        EMIT
    } seq_state_t;

    typedef struct packed {
        logic [CHAR_W-1:0] char;
        logic [CODE_W-1:0] code;
        logic [LEN_W-1:0]  len;
    } huff_sym_t;

endpackage

// File: rtl/huff_char_buffer.sv
// huff_char_buffer: MAX_CHAR_LENGTH-entry character store for one input block.
//
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset, fills every entry with PAD_CHAR
//   clr_i      synchronous clear, same effect as reset, has priority over writes
//   wr_en_i    write strobe
//   wr_addr_i  entry to write (0..MAX_CHAR_LENGTH-1)
//   wr_data_i  character to write
//   data_o     packed read-out, entry 0 in the LSBs
module huff_char_buffer
    import huff_pkg::*;
#(
    parameter logic [CHAR_W-1:0] PAD_CHAR = PAD_CHAR_DEF
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clr_i,
    input  logic                              wr_en_i,
    input  logic [CNT_W-1:0]                  wr_addr_i,
    input  logic [CHAR_W-1:0]                 wr_data_i,
    output logic [MAX_CHAR_LENGTH*CHAR_W-1:0] data_o
);

    logic [CHAR_W-1:0] mem_q [MAX_CHAR_LENGTH];

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            for (int i = 0; i < MAX_CHAR_LENGTH; i++) begin
                mem_q[i] <= PAD_CHAR;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_CHAR_LENGTH; i++) begin
            data_o[i*CHAR_W +: CHAR_W] = mem_q[i];
        end
    end

endmodule

// File: rtl/huff_enc_seq.sv
// huff_enc_seq: sequential front/back end around the combinational Huffman
// encoder. Packs up to MAX_CHAR_LENGTH characters into a block, holds the
// block on the encoder with enc_data_en for SETTLE_CYCLES, snapshots the
// per-position codes and streams them out one symbol per handshake.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   in_valid_i/in_ready_o character handshake; in_char_i, in_last_i payload
//   enc_data_in_o         packed block to encoder, position 0 in the LSBs
//   enc_data_en_o         encoder enable (high while settling)
//   enc_count_o           valid positions in the block, 1..MAX_CHAR_LENGTH
//   enc_code_i, enc_len_i per-position code/length from the encoder
//   out_valid_o/out_ready_i symbol handshake; out_char_o, out_code_o,
//                         out_len_o, out_last_o payload
//   busy_o                high whenever not in FILL
//
// Optional feature macro HUFF_SEQ_STATS_EN adds saturating 32-bit counters
//   stat_chars_o (characters accepted) and stat_bits_o (sum of emitted out_len).
module huff_enc_seq
    import huff_pkg::*;
#(
    parameter int                SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter logic [CHAR_W-1:0] PAD_CHAR      = PAD_CHAR_DEF
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [CHAR_W-1:0]                 in_char_i,
    input  logic                              in_last_i,
    output logic [MAX_CHAR_LENGTH*CHAR_W-1:0] enc_data_in_o,
    output logic                              enc_data_en_o,
    output logic [CNT_W-1:0]                  enc_count_o,
    input  logic [MAX_CHAR_LENGTH*CODE_W-1:0] enc_code_i,
    input  logic [MAX_CHAR_LENGTH*LEN_W-1:0]  enc_len_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [CHAR_W-1:0]                 out_char_o,
    output logic [CODE_W-1:0]                 out_code_o,
    output logic [LEN_W-1:0]                  out_len_o,
    output logic                              out_last_o,
    output logic                              busy_o
`ifdef HUFF_SEQ_STATS_EN
    ,
    output logic [31:0]                       stat_chars_o,
    output logic [31:0]                       stat_bits_o
`endif
);

    localparam int SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WR_LAST     = CNT_W'(MAX_CHAR_LENGTH - 1);

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SCNT_W-1:0] settle_q, settle_d;
    huff_sym_t         snap_q [MAX_CHAR_LENGTH];
    huff_sym_t         cur_sym;

    logic buf_we;
    logic buf_clr;
    logic snap_we;
    logic in_fire;
    logic out_fire;
    logic last_sym;
    logic [MAX_CHAR_LENGTH*CHAR_W-1:0] buf_data;

    huff_char_buffer #(
        .PAD_CHAR (PAD_CHAR)
    ) u_buffer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (buf_clr),
        .wr_en_i   (buf_we),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_char_i),
        .data_o    (buf_data)
    );

    assign in_ready_o    = (state_q == FILL);
    assign enc_data_en_o = (state_q == SETTLE);
    assign out_valid_o   = (state_q == EMIT);
    assign busy_o        = (state_q != FILL);
    assign enc_data_in_o = buf_data;
    assign enc_count_o   = count_q;

    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_o && out_ready_i;
    assign last_sym = (rd_ptr_q == count_q - CNT_W'(1));

    // Output fields read straight from the snapshot, forced to zero outside
    // EMIT so idle outputs never show stale symbols.
    assign cur_sym    = snap_q[rd_ptr_q];
    assign out_char_o = out_valid_o ? cur_sym.char : '0;
    assign out_code_o = out_valid_o ? cur_sym.code : '0;
    assign out_len_o  = out_valid_o ? cur_sym.len  : '0;
    assign out_last_o = out_valid_o && last_sym;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        settle_d = settle_q;
        buf_we   = 1'b0;
        buf_clr  = 1'b0;
        snap_we  = 1'b0;
        case (state_q)
            FILL: begin
                if (in_fire) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + CNT_W'(1);
                    // A full block closes regardless of in_last.
                    if (wr_ptr_q == WR_LAST || in_last_i) begin
                        state_d  = SETTLE;
                        count_d  = wr_ptr_q + CNT_W'(1);
                        settle_d = '0;
                    end
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    snap_we  = 1'b1;
                    settle_d = '0;
                    rd_ptr_d = '0;
                    state_d  = EMIT;
                end else begin
                    settle_d = settle_q + SCNT_W'(1);
                end
            end
            EMIT: begin
                if (out_fire) begin
                    if (last_sym) begin
                        buf_clr  = 1'b1;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        count_d  = '0;
                        state_d  = FILL;
                    end else begin
                        rd_ptr_d = rd_ptr_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            settle_q <= settle_d;
        end
    end

    // The encoder output is sampled on the last settle cycle, while the block
    // is still held on enc_data_in and enc_data_en is high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_CHAR_LENGTH; i++) begin
                snap_q[i] <= '0;
            end
        end else if (snap_we) begin
            for (int i = 0; i < MAX_CHAR_LENGTH; i++) begin
                snap_q[i].char <= buf_data[i*CHAR_W +: CHAR_W];
                snap_q[i].code <= enc_code_i[i*CODE_W +: CODE_W];
                snap_q[i].len  <= enc_len_i[i*LEN_W +: LEN_W];
            end
        end
    end

`ifdef HUFF_SEQ_STATS_EN
    logic [31:0] stat_chars_q;
    logic [31:0] stat_bits_q;
    logic [32:0] bits_sum;

    assign bits_sum     = {1'b0, stat_bits_q} + 33'(out_len_o);
    assign stat_chars_o = stat_chars_q;
    assign stat_bits_o  = stat_bits_q;

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_chars_q <= '0;
            stat_bits_q  <= '0;
        end else begin
            if (in_fire && (stat_chars_q != '1)) begin
                stat_chars_q <= stat_chars_q + 32'd1;
            end
            if (out_fire) begin
                stat_bits_q <= bits_sum[32] ? '1 : bits_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_huff_enc_seq.sv
// tb_huff_enc_seq: self-checking bench for huff_enc_seq. An encoder stub
// answers each position i with code {char, i+1} and len i+1 while enabled
// (all ones otherwise); expected symbols are derived from the characters sent.
module tb_huff_enc_seq;
    import huff_pkg::*;

    typedef logic [6:0] chq_t[$];

    typedef struct packed {
        logic [6:0]  ch;
        logic [14:0] code;
        logic [3:0]  len;
        logic        last;
    } sym_t;

    typedef sym_t sym_q_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_char;
    logic        in_last;
    logic [34:0] enc_data_in;
    logic        enc_data_en;
    logic [2:0]  enc_count;
    logic [74:0] enc_code;
    logic [19:0] enc_len;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_char;
    logic [14:0] out_code;
    logic [3:0]  out_len;
    logic        out_last;
    logic        busy;
`ifdef HUFF_SEQ_STATS_EN
    logic [31:0] stat_chars;
    logic [31:0] stat_bits;
`endif

    int checks   = 0;
    int passes   = 0;
    int cyc      = 0;
    int en_total = 0;

    huff_enc_seq dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_char_i     (in_char),
        .in_last_i     (in_last),
        .enc_data_in_o (enc_data_in),
        .enc_data_en_o (enc_data_en),
        .enc_count_o   (enc_count),
        .enc_code_i    (enc_code),
        .enc_len_i     (enc_len),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_char_o    (out_char),
        .out_code_o    (out_code),
        .out_len_o     (out_len),
        .out_last_o    (out_last),
        .busy_o        (busy)
`ifdef HUFF_SEQ_STATS_EN
        ,
        .stat_chars_o  (stat_chars),
        .stat_bits_o   (stat_bits)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (enc_data_en) en_total++;
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            if (enc_data_en) begin
                enc_code[i*15 +: 15] = {enc_data_in[i*7 +: 7], 8'(i + 1)};
                enc_len[i*4 +: 4]    = 4'(i + 1);
            end else begin
                enc_code[i*15 +: 15] = '1;
                enc_len[i*4 +: 4]    = '1;
            end
        end
    end

    function automatic chq_t str2q(input string s);
        chq_t q;
        byte  b;
        q = {};
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            q.push_back(b[6:0]);
        end
        return q;
    endfunction

    function automatic logic [34:0] pack_block(input chq_t cs);
        logic [34:0] p;
        p = '0;
        for (int i = 0; i < cs.size(); i++) p[i*7 +: 7] = cs[i];
        return p;
    endfunction

    function automatic sym_t exp_sym(input logic [6:0] c, input int i, input int n);
        sym_t s;
        s.ch   = c;
        s.code = {c, 8'(i + 1)};
        s.len  = 4'(i + 1);
        s.last = (i == n - 1);
        return s;
    endfunction

    function automatic chq_t rand_chars(input int n);
        chq_t q;
        q = {};
        for (int i = 0; i < n; i++) q.push_back(7'($urandom_range(32, 126)));
        return q;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_char   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_block(input chq_t cs, input bit use_last,
                              output int first_hs, output int last_hs, output bit ok);
        ok       = 1'b1;
        first_hs = -1;
        last_hs  = -1;
        for (int k = 0; k < cs.size(); k++) begin
            int guard;
            guard    = 0;
            in_valid = 1'b1;
            in_char  = cs[k];
            in_last  = use_last && (k == cs.size() - 1);
            while (!in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) begin
                ok = 1'b0;
                break;
            end
            if (k == 0) first_hs = cyc;
            last_hs = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input int n, input bit rnd, output sym_q_t got,
                           output int first_cyc, output int last_cyc);
        int   budget;
        sym_t s;
        budget    = 0;
        got       = {};
        first_cyc = -1;
        last_cyc  = -1;
        while (got.size() < n && budget < 300) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (out_valid && out_ready) begin
                s.ch   = out_char;
                s.code = out_code;
                s.len  = out_len;
                s.last = out_last;
                got.push_back(s);
                last_cyc = cyc;
            end
            @(negedge clk);
            budget++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({in_ready, enc_data_en, out_valid, out_last, busy} !== 5'b10000) begin
            $display("[TB] FAIL reset_ctrl: got %b, expected 10000", {in_ready, enc_data_en, out_valid, out_last, busy});
        end else passes++;
        checks++;
        if (enc_count !== 3'd0) $display("[TB] FAIL reset_count: got %0d, expected 0", enc_count);
        else passes++;
        checks++;
        if ({out_char, out_code, out_len} !== 26'd0 || enc_data_in !== 35'd0) begin
            $display("[TB] FAIL reset_data: got out=%h data=%h, expected 0", {out_char, out_code, out_len}, enc_data_in);
        end else passes++;
    endtask

    task automatic test_full_block();
        chq_t   cs;
        sym_q_t got;
        int     f_hs, l_hs, fc, lc, en0;
        bit     ok;
        $display("[TB] full block \"ae aa\"");
        cs  = str2q("ae aa");
        en0 = en_total;
        send_block(cs, 1'b0, f_hs, l_hs, ok);
        checks++;
        if (!ok) $display("[TB] FAIL full_send: got timeout, expected all accepted");
        else passes++;
        checks++;
        if (enc_data_in !== pack_block(cs)) $display("[TB] FAIL full_data_in: got %h, expected %h", enc_data_in, pack_block(cs));
        else passes++;
        checks++;
        if (enc_count !== 3'd5 || busy !== 1'b1) $display("[TB] FAIL full_count: got %0d busy %b, expected 5 busy 1", enc_count, busy);
        else passes++;
        collect(5, 1'b0, got, fc, lc);
        checks++;
        if (fc !== l_hs + 3) $display("[TB] FAIL full_latency: got %0d cycles, expected 3", fc - l_hs);
        else passes++;
        checks++;
        if (got.size() != 5) $display("[TB] FAIL full_nsym: got %0d, expected 5", got.size());
        else passes++;
        for (int k = 0; k < got.size(); k++) begin
            checks++;
            if (got[k] !== exp_sym(cs[k], k, 5)) $display("[TB] FAIL full_sym%0d: got %h, expected %h", k, got[k], exp_sym(cs[k], k, 5));
            else passes++;
        end
        checks++;
        if (en_total - en0 != 2) $display("[TB] FAIL full_en_cycles: got %0d, expected 2", en_total - en0);
        else passes++;
    endtask

    task automatic test_single();
        chq_t   cs;
        sym_q_t got;
        int     f_hs, l_hs, fc, lc, extra;
        bit     ok;
        $display("[TB] single char with in_last");
        cs = str2q("x");
        send_block(cs, 1'b1, f_hs, l_hs, ok);
        checks++;
        if (!ok || enc_count !== 3'd1) $display("[TB] FAIL single_count: got %0d, expected 1", enc_count);
        else passes++;
        checks++;
        if (enc_data_in[34:7] !== 28'd0 || enc_data_in[6:0] !== 7'h78) $display("[TB] FAIL single_pad: got %h, expected 0000000078", enc_data_in);
        else passes++;
        collect(1, 1'b0, got, fc, lc);
        checks++;
        if (got.size() != 1 || got[0] !== exp_sym(7'h78, 0, 1)) begin
            $display("[TB] FAIL single_sym: got %0d syms first %h, expected 1 sym %h", got.size(), (got.size() > 0) ? got[0] : '0, exp_sym(7'h78, 0, 1));
        end else passes++;
        extra = 0;
        out_ready = 1'b1;
        repeat (6) begin
            if (out_valid) extra++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (extra != 0) $display("[TB] FAIL single_no_pad_out: got %0d extra outputs, expected 0", extra);
        else passes++;
    endtask

    task automatic test_stall();
        chq_t cs;
        sym_t cur, prev;
        bit   pat[4];
        bit   held, ok;
        int   idx, k, budget, f_hs, l_hs;
        $display("[TB] stalled output");
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        cs  = rand_chars(5);
        send_block(cs, 1'b0, f_hs, l_hs, ok);
        idx = 0; k = 0; budget = 0; held = 1'b0; prev = '0;
        while (idx < 5 && budget < 200) begin
            out_ready = out_valid ? pat[k % 4] : 1'b0;
            if (out_valid) begin
                cur.ch = out_char; cur.code = out_code; cur.len = out_len; cur.last = out_last;
                if (held) begin
                    checks++;
                    if (cur !== prev) $display("[TB] FAIL stall_hold: got %h, expected %h", cur, prev);
                    else passes++;
                end
                checks++;
                if (in_ready !== 1'b0) $display("[TB] FAIL stall_in_ready: got %b, expected 0", in_ready);
                else passes++;
                if (out_ready) begin
                    checks++;
                    if (cur !== exp_sym(cs[idx], idx, 5)) $display("[TB] FAIL stall_sym%0d: got %h, expected %h", idx, cur, exp_sym(cs[idx], idx, 5));
                    else passes++;
                    idx++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    prev = cur;
                end
                k++;
            end
            @(negedge clk);
            budget++;
        end
        out_ready = 1'b0;
        checks++;
        if (idx != 5) $display("[TB] FAIL stall_nsym: got %0d, expected 5", idx);
        else passes++;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("[TB] FAIL stall_return: got in_ready %b out_valid %b, expected 1 0", in_ready, out_valid);
        else passes++;
    endtask

    task automatic test_reset_in_settle();
        chq_t   cs;
        sym_q_t got;
        int     f_hs, l_hs, fc, lc, extra;
        bit     ok;
        $display("[TB] reset during settle");
        cs = str2q("qrs");
        send_block(cs, 1'b1, f_hs, l_hs, ok);
        checks++;
        if (enc_data_en !== 1'b1) $display("[TB] FAIL rst_pre_settle: got en %b, expected 1", enc_data_en);
        else passes++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({in_ready, enc_data_en, out_valid, busy} !== 4'b1000 || enc_count !== 3'd0) begin
            $display("[TB] FAIL rst_state: got %b count %0d, expected 1000 count 0", {in_ready, enc_data_en, out_valid, busy}, enc_count);
        end else passes++;
        extra = 0;
        repeat (5) begin
            if (out_valid) extra++;
            @(negedge clk);
        end
        checks++;
        if (extra != 0) $display("[TB] FAIL rst_no_output: got %0d outputs, expected 0", extra);
        else passes++;
        cs = str2q("bb");
        send_block(cs, 1'b1, f_hs, l_hs, ok);
        checks++;
        if (enc_data_in !== pack_block(cs) || enc_count !== 3'd2) $display("[TB] FAIL rst_next_block: got %h count %0d, expected %h count 2", enc_data_in, enc_count, pack_block(cs));
        else passes++;
        collect(2, 1'b0, got, fc, lc);
        checks++;
        if (got.size() != 2 || got[0] !== exp_sym(7'h62, 0, 2) || got[1] !== exp_sym(7'h62, 1, 2)) begin
            $display("[TB] FAIL rst_bb_syms: got %0d syms, expected two 'b' symbols", got.size());
        end else passes++;
    endtask

    task automatic test_back_to_back();
        chq_t   cs1, cs2;
        sym_q_t got;
        int     f_hs, l_hs, fc, lc;
        bit     ok;
        $display("[TB] back-to-back blocks");
        cs1 = str2q("abcde");
        cs2 = str2q("fg");
        send_block(cs1, 1'b0, f_hs, l_hs, ok);
        collect(5, 1'b0, got, fc, lc);
        checks++;
        if (got.size() != 5 || got[4] !== exp_sym(7'h65, 4, 5)) $display("[TB] FAIL b2b_first: got %0d syms, expected 5 ending in 'e'", got.size());
        else passes++;
        send_block(cs2, 1'b1, f_hs, l_hs, ok);
        checks++;
        if (f_hs !== lc + 1) $display("[TB] FAIL b2b_gap: got first accept %0d cycles after last output, expected 1", f_hs - lc);
        else passes++;
        checks++;
        if (enc_count !== 3'd2) $display("[TB] FAIL b2b_count: got %0d, expected 2", enc_count);
        else passes++;
        collect(2, 1'b0, got, fc, lc);
        checks++;
        if (got.size() != 2 || got[0] !== exp_sym(7'h66, 0, 2) || got[1] !== exp_sym(7'h67, 1, 2)) begin
            $display("[TB] FAIL b2b_second: got %0d syms, expected 'f','g'", got.size());
        end else passes++;
    endtask

    task automatic test_random();
        chq_t   cs;
        sym_q_t got;
        int     n, f_hs, l_hs, fc, lc;
        bit     use_last, ok;
        $display("[TB] random blocks");
        for (int b = 0; b < 10; b++) begin
            n        = $urandom_range(1, 5);
            use_last = (n < 5) ? 1'b1 : 1'($urandom_range(0, 1));
            cs       = rand_chars(n);
            send_block(cs, use_last, f_hs, l_hs, ok);
            checks++;
            if (!ok || enc_count !== 3'(n)) $display("[TB] FAIL rand_count%0d: got %0d, expected %0d", b, enc_count, n);
            else passes++;
            // Garbage on the input side while the block is busy must be ignored.
            in_valid = 1'b1;
            in_char  = 7'($urandom_range(0, 127));
            in_last  = 1'($urandom_range(0, 1));
            collect(n, 1'b1, got, fc, lc);
            in_valid = 1'b0;
            in_last  = 1'b0;
            checks++;
            if (got.size() != n) $display("[TB] FAIL rand_nsym%0d: got %0d, expected %0d", b, got.size(), n);
            else passes++;
            for (int k = 0; k < got.size(); k++) begin
                checks++;
                if (got[k] !== exp_sym(cs[k], k, n)) $display("[TB] FAIL rand_sym%0d_%0d: got %h, expected %h", b, k, got[k], exp_sym(cs[k], k, n));
                else passes++;
            end
        end
    endtask

`ifdef HUFF_SEQ_STATS_EN
    task automatic test_stats();
        chq_t   cs;
        sym_q_t got;
        int     f_hs, l_hs, fc, lc;
        bit     ok;
        $display("[TB] statistics counters");
        do_reset();
        checks++;
        if (stat_chars !== 32'd0 || stat_bits !== 32'd0) $display("[TB] FAIL stats_reset: got %0d/%0d, expected 0/0", stat_chars, stat_bits);
        else passes++;
        cs = str2q("ae aa");
        send_block(cs, 1'b0, f_hs, l_hs, ok);
        collect(5, 1'b0, got, fc, lc);
        cs = str2q("x");
        send_block(cs, 1'b1, f_hs, l_hs, ok);
        collect(1, 1'b0, got, fc, lc);
        checks++;
        if (stat_chars !== 32'd6) $display("[TB] FAIL stats_chars: got %0d, expected 6", stat_chars);
        else passes++;
        checks++;
        if (stat_bits !== 32'd16) $display("[TB] FAIL stats_bits: got %0d, expected 16", stat_bits);
        else passes++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_char   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_full_block();
        test_single();
        test_stall();
        test_reset_in_settle();
        test_back_to_back();
        test_random();
`ifdef HUFF_SEQ_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/huff_enc_seq.md
Name: huff_enc_seq

Overview:
Sequential front/back end for the combinational Huffman encoder datapath.
- Accepts a byte stream of 7-bit characters over valid/ready and packs up to MAX_CHAR_LENGTH of them into a block.
- Presents the block to the encoder with data_en held for a fixed settle window.
- Captures the per-position codes and streams them out one symbol per handshake.
- Sits between the character source and the bit packer. The encoder stays purely combinational.

Parameters:
MAX_CHAR_LENGTH, 5, characters per block; must match the encoder build.
CODE_W, 15, code width per position (2*6+3, matches the encoder output width).
LEN_W, 4, width of the code-length field.
SETTLE_CYCLES, 2, cycles data_en is held before codes are sampled; must be at least 1.
PAD_CHAR, 7'h00, value driven on unused enc_data_in positions.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  source has a character.
in_ready  out  1  block accepts a character.
in_char  in  7  ASCII character.
in_last  in  1  character closes the block early.
enc_data_in  out  MAX_CHAR_LENGTH*7  packed block to encoder; position 0 in the LSBs.
enc_data_en  out  1  encoder enable.
enc_count  out  3  number of valid positions, 1..MAX_CHAR_LENGTH.
enc_code  in  MAX_CHAR_LENGTH*CODE_W  code per input position.
enc_len  in  MAX_CHAR_LENGTH*LEN_W  code length per input position.
out_valid  out  1  output symbol available.
out_ready  in  1  sink accepts the symbol.
out_char  out  7  character being emitted.
out_code  out  CODE_W  its code, right-aligned.
out_len  out  LEN_W  its code length.
out_last  out  1  final symbol of the block.
busy  out  1  high in any state other than FILL.

Behaviour:
- States: FILL, SETTLE, EMIT.
- Reset values: state=FILL, wr_ptr=0, rd_ptr=0, settle_cnt=0, buffer=PAD_CHAR. Outputs: in_ready=1, enc_data_en=0, out_valid=0, out_last=0, busy=0, enc_count=0, out_code/out_len/out_char=0.
- FILL:
  - in_ready=1.
  - On in_valid&&in_ready: buf[wr_ptr]<=in_char and wr_ptr++.
  - If wr_ptr==MAX_CHAR_LENGTH-1 or in_last, go to SETTLE next cycle with enc_count=wr_ptr+1.
  - Positions at and above enc_count stay PAD_CHAR.
- SETTLE:
  - in_ready=0 and enc_data_en=1; enc_data_in is held stable.
  - settle_cnt counts 0..SETTLE_CYCLES-1.
  - On the last count, enc_code/enc_len are registered into a snapshot array and state becomes EMIT.
- EMIT:
  - enc_data_en=0.
  - out_valid=1 with out_* taken from snapshot[rd_ptr]; out_last=(rd_ptr==enc_count-1).
  - On out_valid&&out_ready: rd_ptr++.
  - On the last handshake: clear buffer to PAD_CHAR, zero wr_ptr/rd_ptr/enc_count, return to FILL.
  - With out_ready low, all out_* are held stable.
- Latency: the first out_valid occurs SETTLE_CYCLES+1 cycles after the accepting handshake of the last character.
- Boundary conditions:
  - in_last on the first character gives a block of enc_count=1.
  - A full block ignores in_last (it is redundant).
  - in_valid during SETTLE or EMIT is not accepted.
  - No character is accepted in the same cycle EMIT returns to FILL; in_ready rises the following cycle.
  - A code longer than CODE_W is not checked: the controller passes through whatever the encoder presents.
  - rst asserted in any state: next cycle equals the reset values above and the partial block is discarded.
  - No output is produced for PAD positions.

Optional Feature:
HUFF_SEQ_STATS_EN
- Defined: adds outputs stat_chars (32 bit, characters accepted) and stat_bits (32 bit, sum of out_len over emitted symbols).
  - Both increment on their handshakes and saturate at all-ones.
  - Both clear on rst.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package huff_pkg holds:
  - MAX_CHAR_LENGTH, CODE_W, LEN_W;
  - the typedef enum logic[1:0] {FILL, SETTLE, EMIT} seq_state_t;
  - the typedef struct packed {char, code, len} huff_sym_t used for the snapshot.
- One sub-module: huff_char_buffer.
  - Write port, clear, and packed read-out of MAX_CHAR_LENGTH 7-bit entries.
  - Used for the input block; the snapshot is registered in the top.

Test Plan:
1. Encoder stub returning code=i+1, len=i+1. Feed "ae aa" (full block) with out_ready=1.
   - Expect 5 outputs: chars 'a','e',' ','a','a' with codes 1..5 and lens 1..5; out_last on the 5th.
   - enc_data_en high for exactly 2 cycles.
2. Feed 'x' with in_last.
   - Expect enc_count=1, positions 1..4 = 7'h00, a single output with out_last=1.
3. Feed 5 characters, then toggle out_ready 1,0,0,1,...
   - Expect out_* stable while stalled, no loss or duplication, in_ready=0 until after the last handshake.
4. Assert rst in SETTLE after 3 characters.
   - Expect no output, then state FILL, in_ready=1, enc_data_en=0.
   - The next block "bb" emits only 'b','b'.
5. Two back-to-back blocks "abcde" then "fg" with in_last.
   - Expect exactly one idle cycle between the two blocks; second block enc_count=2.
6. With HUFF_SEQ_STATS_EN defined, run test 1 then test 2.
   - Expect stat_chars=6 and stat_bits=16 (15+1).
